loa_stream_accumulator: RTL and testbench

- Streaming accumulator that consumes operand beats and sums each packet using lower-part-OR approximate addition.
- Each beat is added to a running 32-bit accumulator. The addition is bitwise OR on the low LOWER bits; the upper bits use exact addition with carry-in a[LOWER-1]&b[LOWER-1].
- Placed directly downstream of the 32-bit LOA adder datapath in the approximate-arithmetic test chain. Provides packet framing, overflow tracking and a valid/ready output.

---
 rtl/loa_stream_accumulator.sv | 115 +++++++++++
 tb/tb_loa_stream_accumulator.sv | 351 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/loa_stream_accumulator.sv
// Packet accumulator using lower-part-OR approximate addition: OR on the low LOWER
// bits, exact add above with carry-in taken from the top approximate bit pair.
module loa_stream_accumulator #(
  parameter int WIDTH    = 32,
  parameter int LOWER    = 8,
  parameter int CNT_W    = 8,
  parameter bit SATURATE = 1'b1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [WIDTH-1:0] in_data_i,
  input  logic             in_last_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] out_sum_o,
  output logic             out_ovf_o,
  output logic [CNT_W-1:0] out_count_o,
  output logic [1:0]       dbg_state_o
);

  // Handshake: a beat transfers on a rising edge with in_valid_i && in_ready_o;
  // a result transfers on a rising edge with out_valid_o && out_ready_i.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   acc_q, acc_d;
  logic               ovf_q, ovf_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               ready_q, valid_q;

  logic               accept;
  logic               carry_in;
  logic [LOWER-1:0]   lower_or;
  logic [WIDTH-LOWER:0] upper_sum;
  logic [WIDTH-1:0]   loa_sum;
  logic               loa_carry;

  assign accept    = in_valid_i & ready_q;
  assign lower_or  = acc_q[LOWER-1:0] | in_data_i[LOWER-1:0];
  assign carry_in  = acc_q[LOWER-1] & in_data_i[LOWER-1];
  assign upper_sum = {1'b0, acc_q[WIDTH-1:LOWER]}
                   + {1'b0, in_data_i[WIDTH-1:LOWER]}
                   + {{(WIDTH-LOWER){1'b0}}, carry_in};
  assign loa_sum   = {upper_sum[WIDTH-LOWER-1:0], lower_or};
  assign loa_carry = upper_sum[WIDTH-LOWER];

  // Data registers only load on an accepted beat, so idle-cycle X on in_data_i never lands in acc.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    ovf_d   = ovf_q;
    count_d = count_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          acc_d   = in_data_i;
          ovf_d   = 1'b0;
          count_d = CNT_ONE;
          state_d = in_last_i ? HOLD : ACCUM;
        end
      end
      ACCUM: begin
        if (accept) begin
          if (loa_carry) begin
            ovf_d = 1'b1;
            acc_d = SATURATE ? {WIDTH{1'b1}} : loa_sum;
          end else begin
            acc_d = loa_sum;
          end
          if (count_q != CNT_MAX) count_d = count_q + CNT_ONE;
          if (in_last_i) state_d = HOLD;
        end
      end
      HOLD: begin
        if (out_ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      acc_q   <= '0;
      ovf_q   <= 1'b0;
      count_q <= '0;
      ready_q <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      ovf_q   <= ovf_d;
      count_q <= count_d;
      ready_q <= (state_d != HOLD);
      valid_q <= (state_d == HOLD);
    end
  end

  assign in_ready_o  = ready_q;
  assign out_valid_o = valid_q;
  assign out_sum_o   = acc_q;
  assign out_ovf_o   = ovf_q;
  assign out_count_o = count_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_loa_stream_accumulator.sv
// Bench for loa_stream_accumulator: three instances (saturating, wrapping, 2-bit count)
// share one stimulus stream; a reference LOA model feeds a scoreboard queue.
module tb_loa_stream_accumulator;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic [31:0] in_data;
  logic        in_last;
  logic        out_ready;

  logic        ready_s, valid_s, ovf_s;
  logic [31:0] sum_s;
  logic [7:0]  cnt_s;
  logic [1:0]  dbg_s;
  logic        ready_w, valid_w, ovf_w;
  logic [31:0] sum_w;
  logic [7:0]  cnt_w;
  logic [1:0]  dbg_w;
  logic        ready_c, valid_c, ovf_c;
  logic [31:0] sum_c;
  logic [1:0]  cnt_c;
  logic [1:0]  dbg_c;

  int checks   = 0;
  int failures = 0;

  // Expected entry: {inst_c, inst_w, inst_s}, each {ovf, count[7:0], sum[31:0]}
  logic [122:0] exp_q[$];
  logic [122:0] mon_e;

  logic [31:0] m_acc[3];
  logic        m_ovf[3];
  logic [7:0]  m_cnt[3];
  logic        m_first;
  bit          rand_done;

  loa_stream_accumulator #(.WIDTH(32), .LOWER(8), .CNT_W(8), .SATURATE(1'b1)) u_sat (
    .clk_i(clk), .rst_ni(rst_n), .in_valid_i(in_valid), .in_ready_o(ready_s),
    .in_data_i(in_data), .in_last_i(in_last), .out_valid_o(valid_s),
    .out_ready_i(out_ready), .out_sum_o(sum_s), .out_ovf_o(ovf_s),
    .out_count_o(cnt_s), .dbg_state_o(dbg_s));

  loa_stream_accumulator #(.WIDTH(32), .LOWER(8), .CNT_W(8), .SATURATE(1'b0)) u_wrap (
    .clk_i(clk), .rst_ni(rst_n), .in_valid_i(in_valid), .in_ready_o(ready_w),
    .in_data_i(in_data), .in_last_i(in_last), .out_valid_o(valid_w),
    .out_ready_i(out_ready), .out_sum_o(sum_w), .out_ovf_o(ovf_w),
    .out_count_o(cnt_w), .dbg_state_o(dbg_w));

  loa_stream_accumulator #(.WIDTH(32), .LOWER(8), .CNT_W(2), .SATURATE(1'b1)) u_cnt2 (
    .clk_i(clk), .rst_ni(rst_n), .in_valid_i(in_valid), .in_ready_o(ready_c),
    .in_data_i(in_data), .in_last_i(in_last), .out_valid_o(valid_c),
    .out_ready_i(out_ready), .out_sum_o(sum_c), .out_ovf_o(ovf_c),
    .out_count_o(cnt_c), .dbg_state_o(dbg_c));

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  // Reference LOA: OR on bits [7:0], exact add of [31:8] with carry-in a[7]&b[7]
  function automatic logic [32:0] loa_ref(input logic [31:0] a, input logic [31:0] b);
    logic [24:0] hi;
    logic        c;
    c  = a[7] & b[7];
    hi = a[31:8] + b[31:8] + c;
    return {hi, a[7:0] | b[7:0]};
  endfunction

  task automatic model_beat(input logic [31:0] d, input logic last);
    logic [32:0] r;
    logic [7:0]  cmax;
    for (int i = 0; i < 3; i++) begin
      cmax = (i == 2) ? 8'd3 : 8'd255;
      if (m_first) begin
        m_acc[i] = d;
        m_ovf[i] = 1'b0;
        m_cnt[i] = 8'd1;
      end else begin
        r = loa_ref(m_acc[i], d);
        if (r[32]) begin
          m_ovf[i] = 1'b1;
          m_acc[i] = (i == 1) ? r[31:0] : 32'hFFFF_FFFF;
        end else begin
          m_acc[i] = r[31:0];
        end
        if (m_cnt[i] < cmax) m_cnt[i] = m_cnt[i] + 8'd1;
      end
    end
    m_first = 1'b0;
    if (last) begin
      exp_q.push_back({m_ovf[2], m_cnt[2], m_acc[2],
                       m_ovf[1], m_cnt[1], m_acc[1],
                       m_ovf[0], m_cnt[0], m_acc[0]});
      m_first = 1'b1;
    end
  endtask

  // Driver: hold the beat until in_ready is seen, then return at posedge+1 after the transfer
  task automatic send_beat(input logic [31:0] d, input logic last);
    int n;
    n        = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    @(negedge clk);
    while (!ready_s && n < 200) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (!ready_s) begin
      failures++;
      $display("FAIL beat_accept_timeout: in_ready=%b after %0d cycles, required 1", ready_s, n);
    end else begin
      model_beat(d, last);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_data  = 'x;
    in_last  = 1'b0;
  endtask

  // Scoreboard monitor: compare every result handshake against the queue head
  always @(negedge clk) begin
    if (rst_n && valid_s && out_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_result: sum=%h count=%0d with empty expected queue", sum_s, cnt_s);
      end else begin
        mon_e = exp_q.pop_front();
        if ({ovf_s, cnt_s, sum_s} !== mon_e[40:0]) begin
          failures++;
          $display("FAIL sb_sat: ovf/count/sum=%b/%0d/%h required %b/%0d/%h",
                   ovf_s, cnt_s, sum_s, mon_e[40], mon_e[39:32], mon_e[31:0]);
        end
        checks++;
        if ({valid_w, ovf_w, cnt_w, sum_w} !== {1'b1, mon_e[81:41]}) begin
          failures++;
          $display("FAIL sb_wrap: valid/ovf/count/sum=%b/%b/%0d/%h required 1/%b/%0d/%h",
                   valid_w, ovf_w, cnt_w, sum_w, mon_e[81], mon_e[80:73], mon_e[72:41]);
        end
        checks++;
        if ({valid_c, ovf_c, 6'd0, cnt_c, sum_c} !== {1'b1, mon_e[122:82]}) begin
          failures++;
          $display("FAIL sb_cnt2: valid/ovf/count/sum=%b/%b/%0d/%h required 1/%b/%0d/%h",
                   valid_c, ovf_c, cnt_c, sum_c, mon_e[122], mon_e[121:114], mon_e[113:82]);
        end
      end
    end
  end

  task automatic test_reset();
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = 'x;
    in_last   = 1'b0;
    out_ready = 1'b1;
    m_first   = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({valid_s, ready_s, dbg_s} !== 4'b0000) begin
      failures++;
      $display("FAIL reset_ctrl: valid/ready/state=%b/%b/%0d required 0/0/0", valid_s, ready_s, dbg_s);
    end
    checks++;
    if ({ovf_s, cnt_s, sum_s} !== 41'd0) begin
      failures++;
      $display("FAIL reset_data: ovf/count/sum=%b/%0d/%h required 0/0/0", ovf_s, cnt_s, sum_s);
    end
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic test_approx_carry();
    send_beat(32'h0000_00FF, 1'b0);
    checks++;
    if (valid_s !== 1'b0) begin
      failures++;
      $display("FAIL approx_valid_early: out_valid=%b required 0", valid_s);
    end
    send_beat(32'h0000_0080, 1'b1);
    checks++;
    if ({valid_s, ovf_s, cnt_s, sum_s} !== {1'b1, 1'b0, 8'd2, 32'h0000_01FF}) begin
      failures++;
      $display("FAIL approx_result: valid/ovf/count/sum=%b/%b/%0d/%h required 1/0/2/000001ff",
               valid_s, ovf_s, cnt_s, sum_s);
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic test_carry_out();
    send_beat(32'hFFFF_FF00, 1'b0);
    send_beat(32'h0000_0100, 1'b1);
    checks++;
    if ({ovf_s, sum_s} !== {1'b1, 32'hFFFF_FFFF}) begin
      failures++;
      $display("FAIL carry_saturate: ovf/sum=%b/%h required 1/ffffffff", ovf_s, sum_s);
    end
    checks++;
    if ({ovf_w, sum_w} !== {1'b1, 32'h0000_0000}) begin
      failures++;
      $display("FAIL carry_wrap: ovf/sum=%b/%h required 1/00000000", ovf_w, sum_w);
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic test_single_hold();
    out_ready = 1'b0;
    send_beat(32'h1234_5678, 1'b1);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      checks++;
      if ({valid_s, ready_s, dbg_s} !== {1'b1, 1'b0, 2'd2}) begin
        failures++;
        $display("FAIL hold_ctrl[%0d]: valid/ready/state=%b/%b/%0d required 1/0/2", k, valid_s, ready_s, dbg_s);
      end
      checks++;
      if ({ovf_s, cnt_s, sum_s} !== {1'b0, 8'd1, 32'h1234_5678}) begin
        failures++;
        $display("FAIL hold_data[%0d]: ovf/count/sum=%b/%0d/%h required 0/1/12345678", k, ovf_s, cnt_s, sum_s);
      end
      in_valid = (k % 2 == 0);
      in_data  = $urandom;
      in_last  = 1'b1;
    end
    @(posedge clk);
    #1;
    in_valid  = 1'b0;
    in_data   = 'x;
    in_last   = 1'b0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic test_count_saturation();
    for (int k = 0; k < 5; k++) send_beat(32'h0000_0100, k == 4);
    checks++;
    if ({cnt_c, sum_c} !== {2'd3, 32'h0000_0500}) begin
      failures++;
      $display("FAIL cnt_saturate: count/sum=%0d/%h required 3/00000500", cnt_c, sum_c);
    end
    checks++;
    if (cnt_s !== 8'd5) begin
      failures++;
      $display("FAIL cnt_wide: count=%0d required 5", cnt_s);
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic test_reset_mid_packet();
    send_beat(32'h0000_0011, 1'b0);
    send_beat(32'h0000_0022, 1'b0);
    rst_n = 1'b0;
    #1;
    checks++;
    if ({valid_s, ready_s, dbg_s, sum_s} !== {1'b0, 1'b0, 2'd0, 32'd0}) begin
      failures++;
      $display("FAIL reset_mid: valid/ready/state/sum=%b/%b/%0d/%h required 0/0/0/00000000",
               valid_s, ready_s, dbg_s, sum_s);
    end
    m_first = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    send_beat(32'h0000_0001, 1'b0);
    send_beat(32'h0000_0002, 1'b1);
    checks++;
    if ({valid_s, ovf_s, cnt_s, sum_s} !== {1'b1, 1'b0, 8'd2, 32'h0000_0003}) begin
      failures++;
      $display("FAIL after_reset: valid/ovf/count/sum=%b/%b/%0d/%h required 1/0/2/00000003",
               valid_s, ovf_s, cnt_s, sum_s);
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic test_back_to_back();
    rand_done = 1'b0;
    fork
      begin
        for (int p = 0; p < 1000; p++) begin
          int len;
          len = $urandom_range(1, 6);
          for (int b = 0; b < len; b++) begin
            logic [31:0] d;
            case ($urandom_range(0, 3))
              0:       d = $urandom;
              1:       d = $urandom_range(0, 255);
              2:       d = 32'hFFFF_FF00 | $urandom_range(0, 255);
              default: d = $urandom & 32'h00FF_FFFF;
            endcase
            repeat ($urandom_range(0, 2)) begin
              @(posedge clk);
              #1;
            end
            send_beat(d, b == len - 1);
          end
        end
        rand_done = 1'b1;
      end
      begin
        while (!rand_done) begin
          @(posedge clk);
          #1;
          out_ready = ($urandom_range(0, 3) != 0);
        end
        out_ready = 1'b1;
      end
    join
  endtask

  initial begin
    int n;
    test_reset();
    test_approx_carry();
    test_carry_out();
    test_single_hold();
    test_count_saturation();
    test_reset_mid_packet();
    test_back_to_back();
    out_ready = 1'b1;
    n = 0;
    while (exp_q.size() != 0 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain: %0d results outstanding, required 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
